// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel strobe divider, h/v position counters and registered
// sync/blank/coordinate outputs plus start pulses and a sticky vblank interrupt.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 1,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        irq_clr,
    output logic        pixel_clk_en,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_irq
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [10:0]      h_q, h_d, v_q, v_d;
    logic [10:0]      x_q, x_d, y_q, y_d;
    logic             pen_q, pen_d;
    logic             hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic             ls_q, ls_d, fs_q, fs_d, irq_q, irq_d;
    logic             tick, h_wrap, irq_set;

    always_comb begin
        tick    = enable && pen_q;
        h_wrap  = (h_q == H_LAST);
        irq_set = 1'b0;

        div_d = '0;
        if (enable && (div_q != DIV_LAST)) begin
            div_d = div_q + 1'b1;
        end
        // Strobe is registered from the next divider value so it lines up with the tick cycle.
        pen_d = enable && (div_d == DIV_LAST);

        h_d  = h_q;
        v_d  = v_q;
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        x_d  = x_q;
        y_d  = y_q;
        ls_d = 1'b0;
        fs_d = 1'b0;

        if (tick) begin
            h_d = h_wrap ? '0 : h_q + 11'd1;
            if (h_wrap) begin
                v_d     = (v_q == V_LAST) ? '0 : v_q + 11'd1;
                irq_set = (v_d == V_ACT);
            end
            de_d = (h_d < H_ACT) && (v_d < V_ACT);
            hs_d = ((h_d >= HS_BEG) && (h_d < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
            vs_d = ((v_d >= VS_BEG) && (v_d < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
            x_d  = de_d ? h_d : '0;
            y_d  = de_d ? v_d : '0;
            ls_d = (h_d == '0);
            fs_d = (h_d == '0) && (v_d == '0);
        end

        irq_d = irq_set || (irq_q && !irq_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q <= '0;
            h_q   <= H_LAST;
            v_q   <= V_LAST;
            pen_q <= 1'b0;
            hs_q  <= ~HSYNC_POL;
            vs_q  <= ~VSYNC_POL;
            de_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            ls_q  <= 1'b0;
            fs_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            pen_q <= pen_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            x_q   <= x_d;
            y_q   <= y_d;
            ls_q  <= ls_d;
            fs_q  <= fs_d;
            irq_q <= irq_d;
        end
    end

    assign pixel_clk_en = pen_q;
    assign hsync        = hs_q;
    assign vsync        = vs_q;
    assign de           = de_q;
    assign x            = x_q;
    assign y            = y_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign vblank_irq   = irq_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a tiny 15x8 raster with CLK_DIV=2,
// with a per-cycle expected-output queue fed by a position-level reference model.
module tb_vga_timing_gen;

    localparam int CD = 2;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        irq_clr = 1'b0;
    logic        pixel_clk_en, hsync, vsync, de, line_start, frame_start, vblank_irq;
    logic [10:0] x, y;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .irq_clr(irq_clr),
        .pixel_clk_en(pixel_clk_en), .hsync(hsync), .vsync(vsync), .de(de),
        .x(x), .y(y), .line_start(line_start), .frame_start(frame_start),
        .vblank_irq(vblank_irq)
    );

    always #20 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_ls = -1;
    int last_fs = -1;
    logic [28:0] expq[$];

    int mdiv, mh, mv, mx, my;
    bit mpen, m_hs, m_vs, m_de, m_ls, m_fs, m_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [28:0] obs_vec();
        return {pixel_clk_en, hsync, vsync, de, line_start, frame_start, vblank_irq, x, y};
    endfunction

    function automatic logic [28:0] exp_vec();
        return {mpen, m_hs, m_vs, m_de, m_ls, m_fs, m_irq, 11'(mx), 11'(my)};
    endfunction

    task automatic model_update();
        bit fire, set;
        if (!rst_n) begin
            mdiv = 0; mpen = 0; mh = HT - 1; mv = VT - 1;
            m_hs = 1; m_vs = 1; m_de = 0; mx = 0; my = 0;
            m_ls = 0; m_fs = 0; m_irq = 0;
        end else begin
            fire = enable && mpen;
            set  = 0;
            m_ls = 0;
            m_fs = 0;
            if (enable) begin
                mdiv = (mdiv + 1) % CD;
                mpen = (mdiv == CD - 1);
            end else begin
                mdiv = 0;
                mpen = 0;
            end
            if (fire) begin
                mh = mh + 1;
                if (mh == HT) begin
                    mh = 0;
                    mv = (mv + 1) % VT;
                    set = (mv == VA);
                end
                m_de = (mh < HA) && (mv < VA);
                mx   = m_de ? mh : 0;
                my   = m_de ? mv : 0;
                m_hs = !((mh >= HA + HF) && (mh < HA + HF + HS));
                m_vs = !((mv >= VA + VF) && (mv < VA + VF + VS));
                m_ls = (mh == 0);
                m_fs = (mh == 0) && (mv == 0);
            end
            if (set) m_irq = 1;
            else if (irq_clr) m_irq = 0;
        end
    endtask

    task automatic step();
        logic [28:0] e;
        @(posedge clk);
        model_update();
        expq.push_back(exp_vec());
        cyc++;
        @(negedge clk);
        e = expq.pop_front();
        chk("cycle_model", obs_vec(), e);
        if (line_start) begin
            if (last_ls >= 0) chk("ls_spacing", cyc - last_ls, 30);
            last_ls = cyc;
        end
        if (frame_start) begin
            if (last_fs >= 0) chk("fs_spacing", cyc - last_fs, 240);
            last_fs = cyc;
        end
    endtask

    initial begin
        int de_n, hs_n, hs_first, vs_n, vs_first, ymask, off, hi_n, n;
        logic [28:0] snap;

        // 1: reset then first tick
        for (int i = 0; i < 3; i++) step();
        chk("t1_reset_vals", obs_vec(), {7'b0110000, 11'd0, 11'd0});
        rst_n = 1'b1;
        enable = 1'b1;
        step();
        chk("t1_pen_first", pixel_clk_en, 1);
        chk("t1_no_fs_yet", frame_start, 0);
        step();
        chk("t1_first_pos", {frame_start, line_start, de, hsync, vsync, x, y},
            {5'b11111, 11'd0, 11'd0});
        chk("t1_pen_low", pixel_clk_en, 0);

        // 2: one line from h=0
        de_n = 0; hs_n = 0; hs_first = -1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) step();
            if (de) de_n++;
            if (!hsync) begin
                hs_n++;
                if (hs_first < 0) hs_first = i;
            end
        end
        chk("t2_de_clks", de_n, 16);
        chk("t2_hsync_clks", hs_n, 6);
        chk("t2_hsync_start", hs_first, 20);

        // 3: two frames
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 300);
        chk("t3_fs_reached", frame_start, 1);
        vs_n = 0; vs_first = -1; ymask = 0;
        for (int i = 0; i < 480; i++) begin
            if (i > 0) step();
            if (!vsync) begin
                vs_n++;
                if (vs_first < 0) vs_first = i;
            end
            if (de) ymask |= (1 << y);
        end
        chk("t3_vsync_clks", vs_n, 120);
        chk("t3_vsync_start", vs_first, 150);
        chk("t3_y_rows", ymask, 32'hF);

        // 4: vblank interrupt
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 300);
        chk("t4_fs_reached", frame_start, 1);
        chk("t4_irq_sticky", vblank_irq, 1);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("t4_irq_cleared", vblank_irq, 0);
        off = 1;
        while (!vblank_irq && off < 300) begin step(); off++; end
        chk("t4_irq_rise_at", off, 120);
        hi_n = 0;
        for (int i = 0; i < 10; i++) begin step(); if (vblank_irq) hi_n++; end
        chk("t4_irq_holds", hi_n, 10);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("t4_irq_clr2", vblank_irq, 0);
        n = 0;
        do begin step(); n++; end while (!frame_start && n < 300);
        chk("t4_fs_reached2", frame_start, 1);
        for (int i = 0; i < 119; i++) step();
        chk("t4_irq_before_set", vblank_irq, 0);
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        chk("t4_set_wins", vblank_irq, 1);

        // 5: enable freeze at x=5
        n = 0;
        while (!(de && x == 11'd5) && n < 300) begin step(); n++; end
        chk("t5_x5_reached", {de, x}, {1'b1, 11'd5});
        snap = obs_vec();
        last_ls = -1;
        last_fs = -1;
        enable = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("t5_frozen", obs_vec(), snap);
        end
        enable = 1'b1;
        step();
        chk("t5_resume_pen", {pixel_clk_en, x}, {1'b1, 11'd5});
        step();
        chk("t5_resume_x6", x, 6);

        // 6: reset mid-frame with irq pending
        n = 0;
        while (!(vblank_irq && de) && n < 300) begin step(); n++; end
        chk("t6_precond", {vblank_irq, de}, 2'b11);
        last_ls = -1;
        last_fs = -1;
        rst_n = 1'b0;
        step();
        chk("t6_reset_vals", obs_vec(), {7'b0110000, 11'd0, 11'd0});
        rst_n = 1'b1;
        step();
        chk("t6_no_partial", {pixel_clk_en, frame_start, line_start}, 3'b100);
        step();
        chk("t6_first_fs", {frame_start, line_start, x, y}, {2'b11, 11'd0, 11'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the VGA raster timing that drives the VGA controller: the pixel strobe (pixel_clk_en), hsync, vsync, data-enable, and pixel coordinates.
- Also produces frame/line start pulses and a sticky vertical-blank interrupt.
- Sits directly upstream of vga_controller: pixel_clk_en, hsync and vsync feed its pixel_clk_en, hsync_in and vsync_in inputs.
- All outputs are registered.

Parameters:
- CLK_DIV, 1, clk cycles per pixel tick (>=1).
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch in ticks.
- H_SYNC, 96, hsync width in ticks.
- H_BP, 48, horizontal back porch in ticks.
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- HSYNC_POL, 0, hsync asserted level (0 = active-low).
- VSYNC_POL, 0, vsync asserted level (0 = active-low).

Ports:
- clk  in  1  system clock, 25 MHz nominal.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  timing runs while high; all state freezes while low.
- irq_clr  in  1  one-cycle pulse that clears vblank_irq.
- pixel_clk_en  out  1  pixel strobe; counters advance at the end of every cycle in which it is high.
- hsync  out  1  horizontal sync, polarity per HSYNC_POL.
- vsync  out  1  vertical sync, polarity per VSYNC_POL.
- de  out  1  active-video flag.
- x  out  11  column, h_cnt when de=1, otherwise 0.
- y  out  11  row, v_cnt when de=1, otherwise 0.
- line_start  out  1  one-clk pulse when h_cnt reaches 0.
- frame_start  out  1  one-clk pulse when (h_cnt, v_cnt) reaches (0,0).
- vblank_irq  out  1  sticky vertical-blank interrupt.

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be <= 2048; counters are 11-bit.
- Pixel strobe:
  - div_cnt counts 0..CLK_DIV-1 while enable=1.
  - pixel_clk_en=1 in the cycle where div_cnt==CLK_DIV-1.
  - With CLK_DIV=1, pixel_clk_en stays high continuously while enabled.
- Counter advance, at the end of a pixel_clk_en cycle:
  - h_cnt increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, v_cnt increments, wrapping V_TOTAL-1 -> 0.
- Derived outputs, all registered and mutually skew-free. hsync, vsync, de, x and y describe the current (h_cnt, v_cnt) in every cycle:
  - de = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hsync is asserted iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is asserted iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, evaluated per line (vsync changes only together with an h wrap).
- line_start and frame_start: high for exactly one clk, the first cycle at the new position. They are not repeated while CLK_DIV>1 holds that position.
- vblank_irq:
  - Set in the cycle v_cnt becomes V_ACTIVE.
  - Cleared by irq_clr.
  - If set and clear coincide, set wins (vblank_irq=1).
- enable=0:
  - pixel_clk_en=0; div_cnt returns to 0; counters and all outputs hold; start pulses are not regenerated.
  - After enable returns to 1, the next tick occurs after CLK_DIV clks.
- Reset, synchronous (rst_n sampled low at a clk edge):
  - div_cnt=0; h_cnt=H_TOTAL-1; v_cnt=V_TOTAL-1.
  - Outputs: pixel_clk_en=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, de=0, x=0, y=0, line_start=0, frame_start=0, vblank_irq=0.
  - The first tick after reset therefore wraps to (0,0) and emits line_start and frame_start together.
  - Reset mid-frame has the same effect, with no partial pulses.

Test Plan:
Bench parameters for all scenarios: H 8/2/3/2 (H_TOTAL=15), V 4/1/2/1 (V_TOTAL=8), CLK_DIV=2.

1. rst_n low 3 clks, then high with enable=1 -> pixel_clk_en high every 2nd clk. One clk after the first tick: frame_start=1, line_start=1, de=1, x=0, y=0, hsync=vsync=1.
2. Run one line -> de high for 8 ticks (16 clks). hsync low for exactly 6 clks starting at h_cnt=10. line_start pulses 30 clks apart.
3. Run two frames -> vsync low for exactly 2 lines (60 clks) starting at v_cnt=5. frame_start pulses 240 clks apart. y steps 0..3 during de.
4. At v_cnt 3->4 -> vblank_irq rises and stays high until irq_clr. A clr pulse then clears it. A clr pulse coincident with the next set leaves vblank_irq=1.
5. Drop enable at x=5 for 7 clks -> pixel_clk_en=0 and all outputs frozen. After enable returns, x=6 appears 2 clks later.
6. rst_n low 1 clk mid-frame with vblank_irq=1 -> next cycle shows reset values (vblank_irq=0, de=0). The first tick after release emits frame_start.
